score_keeper: RTL and testbench
===============================

Name: score_keeper

Overview:
Producer side of the score→seven-segment path: accumulates the game score as 4 packed BCD digits, tracks lives and remaining pellets, and raises win/lose. Sits between the pacman movement/ghost modules (event pulses in) and the top-level SSD scan logic, which displays score[15:0] nibble-per-digit, so the value must always be valid BCD. Also owns the game-level INIT/PLAY/WIN/LOSE state machine.

Parameters:
PELLET_TOTAL, 244, pellets plus power pellets on the maze; reaching it means a win
LIVES_INIT, 3, lives loaded on start (1..7)
PTS_PELLET, 8'h10, BCD points per pellet (tens/ones digits only)
PTS_POWER, 8'h50, BCD points per power pellet (tens/ones digits only)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  level; begins a game from INIT
ack  in  1  level; acknowledges WIN/LOSE and returns to INIT
pellet_eaten  in  1  one-cycle pulse, normal pellet consumed
power_eaten  in  1  one-cycle pulse, power pellet consumed
ghost_eaten  in  1  one-cycle pulse, frightened ghost eaten
pacman_caught  in  1  one-cycle pulse, pacman killed by a ghost
score  out  16  4 BCD digits, [15:12] = thousands
lives  out  3  remaining lives
pellets_left  out  10  PELLET_TOTAL minus pellets/power pellets eaten this game
playing  out  1  high in PLAY
win  out  1  high in WIN
lose  out  1  high in LOSE

Behaviour:
- Reset (reset=0, async): state INIT, score=16'h0000, lives=0, pellets_left=PELLET_TOTAL, ghost combo=0, playing/win/lose=0.
- INIT: start=1 -> PLAY next cycle; same edge loads score=0, lives=LIVES_INIT, pellets_left=PELLET_TOTAL, combo=0. The previous game's score stays displayed until then.
- PLAY: event pulses act; all registered outputs update on the edge after the pulse (1-cycle latency).
- WIN/LOSE: all event pulses ignored; score frozen. ack=1 -> INIT. start alone does nothing.
- Events outside PLAY are ignored.
- Increment is formed combinationally in BCD:
  - tens/ones = pellet*PTS_PELLET + power*PTS_POWER; defaults give 00, 10, 50 or 60. No intra-increment carry.
  - ghost_eaten adds combo value 0200, 0400, 0800, then 1600. The combo index (0..3) increments per ghost and saturates at 3 (1600).
  - power_eaten clears combo to 0. If power_eaten and ghost_eaten coincide, the ghost is scored at the pre-clear combo value and combo ends at 0.
- score_next = bcd4_add(score, increment). Any carry out of the thousands digit saturates score at 16'h9999.
- pellets_left decrements by 1 per pellet_eaten or power_eaten. If both pulse together, it decrements by 2. It never underflows below 0.
- Win: if pellets_left_next == 0, next state is WIN. Points from the same cycle are still added.
- pacman_caught: lives decrements by 1 and combo clears. If lives_next == 0, next state is LOSE.
- Caught together with the last pellet: the win takes priority, lives is still decremented, and the pellet points are added.
- Simultaneous start and ack in INIT: start wins.
- Asserting reset mid-game returns to reset values immediately, with no pending effects.

Decomposition:
- pacman_pkg holds:
  - typedef enum logic [1:0] game_state_t {INIT, PLAY, WIN, LOSE}
  - localparams for ghost combo BCD values (16'h0200, 16'h0400, 16'h0800, 16'h1600)
  - SCORE_MAX = 16'h9999
- Sub-module bcd4_add: combinational 4-digit BCD adder. Per-digit binary add plus 6-correction, carry chain, saturating output. Reused later by a high-score register.

Test Plan:
- Reset low then high, start pulse -> playing=1, score=0000, lives=3, pellets_left=244 one cycle after start.
- 3 pellet pulses plus 1 power pulse -> score=0080, pellets_left=240. Then pellet and power in the same cycle -> score=0140, pellets_left=238.
- power_eaten, then 5 ghost_eaten pulses -> adds 200, 400, 800, 1600, 1600 (+4600 total). Another power_eaten then ghost_eaten -> +200+50 over that step.
- Preload near max (PELLET_TOTAL large, repeated ghosts) until score=9800, then ghost 1600 -> score=9999, and further events keep 9999.
- With PELLET_TOTAL=2, two pellets -> win=1 and score=0020; subsequent pellet/caught pulses change nothing; ack -> INIT, score still 0020; start -> 0000.
- Three pacman_caught pulses -> lives 2, 1, 0, with lose=1 the cycle after the third. Caught together with the last pellet -> win=1, lives decremented. Reset asserted in PLAY -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/score_keeper_pkg.sv
// Shared types and constants for the score keeper: game FSM encoding,
// BCD ghost-combo point values and datapath widths.
package score_keeper_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    PLAY = 2'd1,
    WIN  = 2'd2,
    LOSE = 2'd3
  } game_state_t;

  localparam int unsigned SCORE_W  = 16;
  localparam int unsigned LIVES_W  = 3;
  localparam int unsigned PELLET_W = 10;
  localparam int unsigned COMBO_W  = 2;

  // Points for the n-th ghost of a combo, packed BCD.
  localparam logic [SCORE_W-1:0] COMBO_PTS_0 = 16'h0200;
  localparam logic [SCORE_W-1:0] COMBO_PTS_1 = 16'h0400;
  localparam logic [SCORE_W-1:0] COMBO_PTS_2 = 16'h0800;
  localparam logic [SCORE_W-1:0] COMBO_PTS_3 = 16'h1600;

  localparam logic [SCORE_W-1:0] SCORE_MAX = 16'h9999;

  // Ghost points for a combo index.
  function automatic logic [SCORE_W-1:0] combo_points(input logic [COMBO_W-1:0] idx);
    logic [SCORE_W-1:0] pts;
    case (idx)
      2'd0:    pts = COMBO_PTS_0;
      2'd1:    pts = COMBO_PTS_1;
      2'd2:    pts = COMBO_PTS_2;
      default: pts = COMBO_PTS_3;
    endcase
    return pts;
  endfunction

endpackage

// File: rtl/score_keeper_if.sv
// Event/handshake bundle between the game logic and the score keeper.
//   master: drives start/ack and event pulses, observes score/status
//   slave : the score keeper itself
interface score_keeper_if;
  import score_keeper_pkg::*;

  logic                start;
  logic                ack;
  logic                pellet_eaten;
  logic                power_eaten;
  logic                ghost_eaten;
  logic                pacman_caught;
  logic [SCORE_W-1:0]  score;
  logic [LIVES_W-1:0]  lives;
  logic [PELLET_W-1:0] pellets_left;
  logic                playing;
  logic                win;
  logic                lose;

  modport master (
    output start, ack, pellet_eaten, power_eaten, ghost_eaten, pacman_caught,
    input  score, lives, pellets_left, playing, win, lose
  );

  modport slave (
    input  start, ack, pellet_eaten, power_eaten, ghost_eaten, pacman_caught,
    output score, lives, pellets_left, playing, win, lose
  );

endinterface

// File: rtl/score_keeper_bcd4_add.sv
// Combinational 4-digit packed-BCD adder (bcd4_add). Operands must be valid
// BCD; a carry out of the thousands digit saturates the result to 9999.
//   a, b  : 16-bit packed BCD operands
//   sum_c : saturated packed BCD sum
module score_keeper_bcd4_add
  import score_keeper_pkg::*;
(
  input  logic [SCORE_W-1:0] a,
  input  logic [SCORE_W-1:0] b,
  output logic [SCORE_W-1:0] sum_c
);

  localparam int unsigned DIGITS = SCORE_W / 4;

  // Ripple the decimal carry digit by digit, applying the +6 correction.
  always_comb begin
    logic [4:0]         digit;
    logic               carry;
    logic [SCORE_W-1:0] raw;
    digit = '0;
    carry = 1'b0;
    raw   = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      digit = 5'(a[i*4 +: 4]) + 5'(b[i*4 +: 4]) + 5'(carry);
      if (digit > 5'd9) begin
        digit = digit + 5'd6;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      raw[i*4 +: 4] = digit[3:0];
    end
    sum_c = carry ? SCORE_MAX : raw;
  end

endmodule

// File: rtl/score_keeper.sv
// Game score keeper: accumulates a packed-BCD score, tracks lives and
// remaining pellets, and runs the INIT/PLAY/WIN/LOSE game state machine.
//   clk, reset : clock, asynchronous active-low reset
//   bus.start/ack             : level controls into the FSM
//   bus.*_eaten/pacman_caught : one-cycle event pulses, honoured in PLAY only
//   bus.score/lives/pellets_left/playing/win/lose : registered status
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int unsigned PELLET_TOTAL = 244,
  parameter int unsigned LIVES_INIT   = 3,
  parameter logic [7:0]  PTS_PELLET   = 8'h10,
  parameter logic [7:0]  PTS_POWER    = 8'h50
) (
  input  logic            clk,
  input  logic            reset,
  score_keeper_if.slave   bus
);

  localparam logic [PELLET_W-1:0] PELLETS_FULL = PELLET_W'(PELLET_TOTAL);
  localparam logic [LIVES_W-1:0]  LIVES_FULL   = LIVES_W'(LIVES_INIT);

  game_state_t         state_q, state_d;
  logic                playing_q, win_q, lose_q;
  logic                playing_d, win_d, lose_d;

  logic [SCORE_W-1:0]  score_q;
  logic [LIVES_W-1:0]  lives_q;
  logic [PELLET_W-1:0] pellets_q;
  logic [COMBO_W-1:0]  combo_q;

  logic                in_play_c;
  logic                pel_c, pow_c, ghost_c, caught_c;
  logic [7:0]          low_inc_c;
  logic [SCORE_W-1:0]  inc_c;
  logic [SCORE_W-1:0]  score_sum_c;
  logic [1:0]          eaten_c;
  logic [PELLET_W-1:0] pellets_next_c;
  logic [LIVES_W-1:0]  lives_next_c;
  logic [COMBO_W-1:0]  combo_next_c;

  // Events only count while a game is in progress.
  assign in_play_c = (state_q == PLAY);
  assign pel_c     = bus.pellet_eaten  & in_play_c;
  assign pow_c     = bus.power_eaten   & in_play_c;
  assign ghost_c   = bus.ghost_eaten   & in_play_c;
  assign caught_c  = bus.pacman_caught & in_play_c;

  // Score increment: pellet/power points in the low byte, ghost combo
  // points in the upper digits (their low byte is always 00).
  always_comb begin
    low_inc_c = (pel_c ? PTS_PELLET : 8'h00) + (pow_c ? PTS_POWER : 8'h00);
    inc_c     = {8'h00, low_inc_c};
    if (ghost_c) begin
      inc_c = inc_c | combo_points(combo_q);
    end
  end

  score_keeper_bcd4_add u_bcd4_add (
    .a     (score_q),
    .b     (inc_c),
    .sum_c (score_sum_c)
  );

  // Pellet count, lives and combo index for the next cycle.
  always_comb begin
    eaten_c = 2'(pel_c) + 2'(pow_c);
    if (pellets_q <= PELLET_W'(eaten_c)) begin
      pellets_next_c = '0;
    end else begin
      pellets_next_c = pellets_q - PELLET_W'(eaten_c);
    end

    lives_next_c = lives_q;
    if (caught_c && (lives_q != '0)) begin
      lives_next_c = lives_q - LIVES_W'(1);
    end

    // The ghost is scored from combo_q before any clear takes effect.
    combo_next_c = combo_q;
    if (pow_c || caught_c) begin
      combo_next_c = '0;
    end else if (ghost_c && (combo_q != COMBO_W'(3))) begin
      combo_next_c = combo_q + COMBO_W'(1);
    end
  end

  // FSM state register, with status flags registered alongside.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= INIT;
      playing_q <= 1'b0;
      win_q     <= 1'b0;
      lose_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      playing_q <= playing_d;
      win_q     <= win_d;
      lose_q    <= lose_d;
    end
  end

  // Next-state logic; an emptied maze outranks a lost last life.
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT: begin
        if (bus.start) state_d = PLAY;
      end
      PLAY: begin
        if (pellets_next_c == '0) begin
          state_d = WIN;
        end else if (caught_c && (lives_next_c == '0)) begin
          state_d = LOSE;
        end
      end
      WIN, LOSE: begin
        if (bus.ack) state_d = INIT;
      end
      default: state_d = INIT;
    endcase
  end

  // Status flags decoded from the state being entered.
  always_comb begin
    playing_d = 1'b0;
    win_d     = 1'b0;
    lose_d    = 1'b0;
    case (state_d)
      PLAY:    playing_d = 1'b1;
      WIN:     win_d     = 1'b1;
      LOSE:    lose_d    = 1'b1;
      default: ;
    endcase
  end

  // Game datapath; previous score stays visible in INIT until the next start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      score_q   <= '0;
      lives_q   <= '0;
      pellets_q <= PELLETS_FULL;
      combo_q   <= '0;
    end else if ((state_q == INIT) && bus.start) begin
      score_q   <= '0;
      lives_q   <= LIVES_FULL;
      pellets_q <= PELLETS_FULL;
      combo_q   <= '0;
    end else if (in_play_c) begin
      score_q   <= score_sum_c;
      lives_q   <= lives_next_c;
      pellets_q <= pellets_next_c;
      combo_q   <= combo_next_c;
    end
  end

  assign bus.score        = score_q;
  assign bus.lives        = lives_q;
  assign bus.pellets_left = pellets_q;
  assign bus.playing      = playing_q;
  assign bus.win          = win_q;
  assign bus.lose         = lose_q;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: decimal-arithmetic game model checked every cycle,
// directed literal checks for the documented scenarios, then random play.
module tb_score_keeper;

  localparam int PT    = 20;
  localparam int LIVES = 3;

  localparam int M_INIT = 0;
  localparam int M_PLAY = 1;
  localparam int M_WIN  = 2;
  localparam int M_LOSE = 3;

  logic clk;
  logic rst_n;

  score_keeper_if bus();

  score_keeper #(
    .PELLET_TOTAL (PT),
    .LIVES_INIT   (LIVES),
    .PTS_PELLET   (8'h10),
    .PTS_POWER    (8'h50)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: score kept as a plain decimal integer.
  int m_state, m_score, m_lives, m_pel, m_combo;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = M_INIT; m_score = 0; m_lives = 0; m_pel = PT; m_combo = 0;
    end else begin
      case (m_state)
        M_INIT: begin
          if (bus.start) begin
            m_state = M_PLAY; m_score = 0; m_lives = LIVES; m_pel = PT; m_combo = 0;
          end
        end
        M_PLAY: begin
          int inc, left;
          inc = 0;
          if (bus.pellet_eaten) inc += 10;
          if (bus.power_eaten)  inc += 50;
          if (bus.ghost_eaten)  inc += 200 * (1 << m_combo);
          m_score = (m_score + inc > 9999) ? 9999 : m_score + inc;
          left = m_pel - int'(bus.pellet_eaten) - int'(bus.power_eaten);
          if (left < 0) left = 0;
          m_pel = left;
          if (bus.pacman_caught && m_lives > 0) m_lives--;
          if (bus.power_eaten || bus.pacman_caught) m_combo = 0;
          else if (bus.ghost_eaten && m_combo < 3) m_combo++;
          if (m_pel == 0) m_state = M_WIN;
          else if (bus.pacman_caught && m_lives == 0) m_state = M_LOSE;
        end
        default: begin
          if (bus.ack) m_state = M_INIT;
        end
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".score"},   32'(bus.score),        32'(to_bcd(m_score)));
    chk({tag, ".lives"},   32'(bus.lives),        32'(m_lives));
    chk({tag, ".pellets"}, 32'(bus.pellets_left), 32'(m_pel));
    chk({tag, ".playing"}, 32'(bus.playing),      32'(m_state == M_PLAY));
    chk({tag, ".win"},     32'(bus.win),          32'(m_state == M_WIN));
    chk({tag, ".lose"},    32'(bus.lose),         32'(m_state == M_LOSE));
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) cmp_model("model");
  end

  // Drive one cycle of inputs at a negedge, return at the next negedge.
  task automatic step(input logic p, input logic pw, input logic g,
                      input logic c, input logic s, input logic a);
    bus.pellet_eaten = p; bus.power_eaten = pw; bus.ghost_eaten = g;
    bus.pacman_caught = c; bus.start = s; bus.ack = a;
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.pellet_eaten = 0; bus.power_eaten = 0; bus.ghost_eaten = 0;
    bus.pacman_caught = 0; bus.start = 0; bus.ack = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset values
    chk("rst.score", 32'(bus.score), 32'h0000);
    chk("rst.lives", 32'(bus.lives), 32'd0);
    chk("rst.pellets", 32'(bus.pellets_left), 32'(PT));
    chk("rst.flags", 32'({bus.playing, bus.win, bus.lose}), 32'd0);

    // Start a game
    step(0, 0, 0, 0, 1, 0);
    chk("start.playing", 32'(bus.playing), 32'd1);
    chk("start.lives", 32'(bus.lives), 32'd3);
    chk("start.pellets", 32'(bus.pellets_left), 32'(PT));

    // Pellets and power pellet
    repeat (3) step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("pel.score", 32'(bus.score), 32'h0080);
    chk("pel.pellets", 32'(bus.pellets_left), 32'(PT - 4));
    step(1, 1, 0, 0, 0, 0);
    chk("both.score", 32'(bus.score), 32'h0140);
    chk("both.pellets", 32'(bus.pellets_left), 32'(PT - 6));

    // Ghost combo: 200, 400, 800, 1600, 1600
    step(0, 1, 0, 0, 0, 0);
    repeat (5) step(0, 0, 1, 0, 0, 0);
    chk("combo.score", 32'(bus.score), 32'h4790);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("recombo.score", 32'(bus.score), 32'h5040);

    // Saturation
    repeat (4) step(0, 0, 1, 0, 0, 0);
    chk("pre_sat.score", 32'(bus.score), 32'h9440);
    step(0, 0, 1, 0, 0, 0);
    chk("sat.score", 32'(bus.score), 32'h9999);
    step(1, 0, 1, 0, 0, 0);
    chk("sat_hold.score", 32'(bus.score), 32'h9999);
    chk("sat_hold.pellets", 32'(bus.pellets_left), 32'(PT - 9));

    // Lose
    step(0, 0, 0, 1, 0, 0);
    chk("caught1.lives", 32'(bus.lives), 32'd2);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("caught3.lives", 32'(bus.lives), 32'd0);
    chk("caught3.lose", 32'(bus.lose), 32'd1);
    step(1, 1, 1, 1, 1, 0);
    chk("lose_frozen.pellets", 32'(bus.pellets_left), 32'(PT - 9));
    chk("lose_start.lose", 32'(bus.lose), 32'd1);
    step(0, 0, 0, 0, 0, 1);
    chk("ack.lose", 32'(bus.lose), 32'd0);
    chk("ack.score_kept", 32'(bus.score), 32'h9999);
    step(0, 0, 0, 0, 1, 0);
    chk("restart.score", 32'(bus.score), 32'h0000);

    // Win with caught on the last pellet
    repeat (PT - 1) step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    chk("win.win", 32'(bus.win), 32'd1);
    chk("win.lives", 32'(bus.lives), 32'd2);
    chk("win.score", 32'(bus.score), 32'h0200);
    chk("win.pellets", 32'(bus.pellets_left), 32'd0);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    chk("start_ack.playing", 32'(bus.playing), 32'd1);

    // Asynchronous reset mid-game
    step(1, 0, 0, 0, 0, 0);
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("arst.score", 32'(bus.score), 32'h0000);
    chk("arst.pellets", 32'(bus.pellets_left), 32'(PT));
    chk("arst.flags", 32'({bus.playing, bus.win, bus.lose, bus.lives}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized play
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 700 == 699) begin
        #3 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      step(($urandom % 3) == 0, ($urandom % 6) == 0, ($urandom % 4) == 0,
           ($urandom % 10) == 0, ($urandom % 6) == 0, ($urandom % 6) == 0);
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
